// File: rtl/ann_layer_sequencer.sv
// rtl/ann_layer_sequencer.sv - three-layer ANN sequencer: coefficient handshake, accumulator clear, MAC sweep, result latch.
module ann_layer_sequencer #(
  parameter int IMAGE_SIZE   = 16,
  parameter int FIRST_LAYER  = 16,
  parameter int SECOND_LAYER = 4,
  parameter int THIRD_LAYER  = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       image_weights_loaded,
  input  logic       abort,
  input  logic       coef_ack,
  output logic       request_coef,
  output logic [1:0] coef_select,
  output logic       reset_accum,
  output logic       mac_en,
  output logic [6:0] input_num,
  output logic [2:0] load_next,
  output logic       done_processing,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IMG,
    REQ_COEF,
    CLR_ACC,
    MAC,
    LATCH,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] layer;

  // input_num is a 7-bit register, so every per-layer input count must fit 1..127
  if (IMAGE_SIZE < 1 || IMAGE_SIZE > 127 || FIRST_LAYER < 1 || FIRST_LAYER > 127 ||
      SECOND_LAYER < 1 || SECOND_LAYER > 127 || THIRD_LAYER < 1) begin : g_bad_params
    $error("ann_layer_sequencer: layer sizes out of range");
  end

  function automatic logic [6:0] layer_len(input logic [1:0] l);
    case (l)
      2'd0:    layer_len = 7'(IMAGE_SIZE);
      2'd1:    layer_len = 7'(FIRST_LAYER);
      default: layer_len = 7'(SECOND_LAYER);
    endcase
  endfunction

  // Outputs are assigned together with the state they belong to, so each one is
  // a registered Moore decode that changes on the same edge as the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      layer           <= 2'd0;
      request_coef    <= 1'b0;
      coef_select     <= 2'd0;
      reset_accum     <= 1'b0;
      mac_en          <= 1'b0;
      input_num       <= 7'd0;
      load_next       <= 3'd0;
      done_processing <= 1'b0;
      busy            <= 1'b0;
    end else begin
      request_coef    <= 1'b0;
      reset_accum     <= 1'b0;
      mac_en          <= 1'b0;
      input_num       <= 7'd0;
      load_next       <= 3'd0;
      done_processing <= 1'b0;
      busy            <= 1'b1;
      coef_select     <= layer;
      if (abort) begin
        state       <= IDLE;
        layer       <= 2'd0;
        busy        <= 1'b0;
        coef_select <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            layer       <= 2'd0;
            coef_select <= 2'd0;
            if (image_weights_loaded) begin
              state     <= LOAD_IMG;
              load_next <= 3'd4;
            end else begin
              busy <= 1'b0;
            end
          end
          LOAD_IMG: begin
            state        <= REQ_COEF;
            request_coef <= 1'b1;
          end
          REQ_COEF: begin
            if (coef_ack) begin
              state       <= CLR_ACC;
              reset_accum <= 1'b1;
            end else begin
              request_coef <= 1'b1;
            end
          end
          CLR_ACC: begin
            state  <= MAC;
            mac_en <= 1'b1;
          end
          MAC: begin
            if (input_num == layer_len(layer) - 7'd1) begin
              state     <= LATCH;
              load_next <= {1'b0, layer} + 3'd1;
            end else begin
              input_num <= input_num + 7'd1;
              mac_en    <= 1'b1;
            end
          end
          LATCH: begin
            if (layer == 2'd2) begin
              state           <= DONE;
              done_processing <= 1'b1;
            end else begin
              layer        <= layer + 2'd1;
              coef_select  <= layer + 2'd1;
              state        <= REQ_COEF;
              request_coef <= 1'b1;
            end
          end
          DONE: begin
            state       <= IDLE;
            layer       <= 2'd0;
            busy        <= 1'b0;
            coef_select <= 2'd0;
          end
          default: begin
            state       <= IDLE;
            layer       <= 2'd0;
            busy        <= 1'b0;
            coef_select <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ann_layer_sequencer.md
ANN_LAYER_SEQUENCER -- requirements
Module: ann_layer_sequencer

Parameters
REQ-001 IMAGE_SIZE, 16, number of image inputs feeding layer 0.
REQ-002 FIRST_LAYER, 16, node count of layer 0, which is also the input count of layer 1.
REQ-003 SECOND_LAYER, 4, node count of layer 1, which is also the input count of layer 2.
REQ-004 THIRD_LAYER, 10, node count of layer 2 (output layer); informational, sets no count.

Interface
REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-006 n_rst  in  1  asynchronous active-low reset.
REQ-007 image_weights_loaded  in  1  start request; sampled only in IDLE.
REQ-008 abort  in  1  synchronous cancel; valid in any state.
REQ-009 coef_ack  in  1  coefficient source reports that the requested layer's weights are valid.
REQ-010 request_coef  out  1  coefficient request for the current layer.
REQ-011 coef_select  out  2  current layer index, 0..2.
REQ-012 reset_accum  out  1  clears the node accumulators.
REQ-013 mac_en  out  1  node MAC enable.
REQ-014 input_num  out  7  index of the input currently being accumulated.
REQ-015 load_next  out  3  pipeline-register load code: 0 hold, 4 image, 1/2/3 layer results.
REQ-016 done_processing  out  1  one-cycle completion pulse.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 All outputs SHALL be registered Moore outputs decoded from state and counters.
REQ-019 States SHALL be IDLE, LOAD_IMG, REQ_COEF, CLR_ACC, MAC, LATCH, DONE.
REQ-020 IDLE -> LOAD_IMG when image_weights_loaded=1; start SHALL be ignored outside IDLE.
REQ-021 LOAD_IMG SHALL last 1 cycle with load_next=4 and layer=0, then go to REQ_COEF.
REQ-022 REQ_COEF SHALL hold request_coef=1 and coef_select=layer until coef_ack=1 is sampled, then go to CLR_ACC; coef_ack SHALL be ignored in all other states.
REQ-023 CLR_ACC SHALL last 1 cycle with reset_accum=1 and input_num=0.
REQ-024 MAC SHALL assert mac_en for exactly N cycles while input_num steps 0..N-1, where N is IMAGE_SIZE, FIRST_LAYER or SECOND_LAYER for layers 0, 1 and 2.
REQ-025 N SHALL be in the range 1..127; input_num SHALL never wrap and SHALL read 0 outside MAC.
REQ-026 LATCH SHALL last 1 cycle with load_next=layer+1; it SHALL then go to REQ_COEF with layer+1 if layer<2, otherwise to DONE.
REQ-027 DONE SHALL last 1 cycle with done_processing=1, then return to IDLE.
REQ-028 load_next SHALL be 0 in every state other than LOAD_IMG and LATCH.
REQ-029 If abort=1 in a non-IDLE state, the next state SHALL be IDLE with all outputs 0 and no done_processing pulse; abort takes priority over coef_ack and start.
REQ-030 If abort and image_weights_loaded are both high in IDLE, the block SHALL stay in IDLE.
REQ-031 With coef_ack held high, done_processing SHALL assert in the 47th cycle after the edge that samples start (default parameters).
REQ-032 Each cycle of coef_ack delay SHALL extend total latency by exactly 1 cycle.

Reset
REQ-033 n_rst=0 SHALL immediately force IDLE, layer=0 and input_num=0, and drive every output to 0, including mid-MAC.
REQ-034 After reset release, the first start SHALL be honoured on the first rising edge with n_rst=1.

Verification
REQ-035 Start pulse, coef_ack tied 1 -> load_next sequence 4,1,2,3 at cycles 1, 20, 39, 46; done_processing at cycle 47; mac_en high for 16+16+4 cycles.
REQ-036 coef_ack delayed 5 cycles on layer 1 only -> request_coef held 6 cycles with coef_select=1; done_processing at cycle 52.
REQ-037 abort at cycle 10 (in layer-0 MAC) -> IDLE at cycle 11, outputs 0, no done pulse; a new start then completes normally in 47 cycles.
REQ-038 n_rst pulsed low mid layer-1 MAC -> outputs 0 asynchronously, busy=0; a restart then completes normally.
REQ-039 image_weights_loaded held high throughout -> a second run starts only after DONE returns to IDLE (done_processing at cycles 47 and 95).
REQ-040 coef_ack pulsed while in MAC, and start pulsed while busy -> no effect; sequence timing unchanged.
